// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and defaults for the pipeline stall controller.
// Holds FSM encoding and per-stage control bundles.
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_WAIT = 2'd2
  } state_e;

  localparam int unsigned MDU_LATENCY_DEF = 32;
  localparam int unsigned MEM_TIMEOUT_DEF = 64;
  localparam int unsigned CNT_W_DEF       = 32;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic ex_mem_bubble;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN    = 7'b1101010;
  localparam stage_ctrl_t CTRL_FREEZE = 7'b0000000;
  localparam stage_ctrl_t CTRL_FLUSH  = 7'b1111110;
  localparam stage_ctrl_t CTRL_MDU    = 7'b0000011;
  localparam stage_ctrl_t CTRL_LDUSE  = 7'b0001110;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating statistics counter with synchronous clear.
// Clear wins over increment in the same cycle.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Arbitrates stall/freeze/flush requests into per-stage
// write enables and bubbles; keeps stall and flush stats.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = MDU_LATENCY_DEF,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_use_hazard,
  input  logic             branch_taken,
  input  logic             mdu_start,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             clr_stats,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             ex_mem_bubble,
  output logic             mdu_busy,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state_dbg
);

  localparam logic [7:0]  LAT_INIT = 8'(MDU_LATENCY - 1);
  localparam logic [31:0] TMO      = 32'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  state_e      run_next;
  logic [7:0]  lat_q, lat_d;
  logic [31:0] tmo_q, tmo_d;
  logic        tout_q, tout_d;
  logic        skip_q, skip_d;
  logic        run_dec;
  logic        run_flush;
  logic        flush_inc;
  logic        stall_inc;
  stage_ctrl_t run_ctrl, ctrl, ctrl_o;

  always_comb begin : run_decode
    run_ctrl  = CTRL_RUN;
    run_next  = RUN;
    run_flush = 1'b0;
    if (branch_taken) begin
      run_ctrl  = CTRL_FLUSH;
      run_flush = 1'b1;
    end else if (mdu_start && !skip_q) begin
      run_ctrl = CTRL_MDU;
      run_next = MDU_WAIT;
    end else if (ld_use_hazard) begin
      run_ctrl = CTRL_LDUSE;
    end
  end

  always_comb begin : fsm
    ctrl    = CTRL_RUN;
    state_d = RUN;
    lat_d   = lat_q;
    tmo_d   = tmo_q;
    tout_d  = tout_q;
    run_dec = 1'b0;
    case (state_q)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          ctrl    = CTRL_FREEZE;
          state_d = MEM_WAIT;
        end else begin
          run_dec = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          ctrl    = CTRL_FREEZE;
          state_d = MEM_WAIT;
          if (tmo_q < TMO) tmo_d = tmo_q + 32'd1;
          if (tmo_q + 32'd1 >= TMO) tout_d = 1'b1;
        end else begin
          tmo_d   = '0;
          run_dec = 1'b1;
        end
      end
      MDU_WAIT: begin
        ctrl = CTRL_MDU;
        if (lat_q > 8'd1) begin
          lat_d   = lat_q - 8'd1;
          state_d = MDU_WAIT;
        end
      end
      default: ;
    endcase
    if (run_dec) begin
      ctrl    = run_ctrl;
      state_d = run_next;
      if (run_next == MDU_WAIT) lat_d = LAT_INIT;
    end
    // the held mult/div must not relaunch on its first RUN cycle
    skip_d = ((state_q == MDU_WAIT) && (state_d == RUN))
           || (skip_q && !run_dec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      lat_q   <= '0;
      tmo_q   <= '0;
      tout_q  <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      tmo_q   <= tmo_d;
      tout_q  <= tout_d;
      skip_q  <= skip_d;
    end
  end

  assign ctrl_o    = rst_n ? ctrl : CTRL_FREEZE;
  assign stall_inc = rst_n && !ctrl.pc_write;
  assign flush_inc = rst_n && run_dec && run_flush;

  assign pc_write      = ctrl_o.pc_write;
  assign if_id_write   = ctrl_o.if_id_write;
  assign if_id_flush   = ctrl_o.if_id_flush;
  assign id_ex_write   = ctrl_o.id_ex_write;
  assign id_ex_bubble  = ctrl_o.id_ex_bubble;
  assign ex_mem_write  = ctrl_o.ex_mem_write;
  assign ex_mem_bubble = ctrl_o.ex_mem_bubble;
  assign mdu_busy      = (state_q == MDU_WAIT);
  assign mem_timeout   = tout_q;
  assign state_dbg     = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .clr   (clr_stats),
    .cnt   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .clr   (clr_stats),
    .cnt   (flush_count)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller with a
// behavioural reference model checked every cycle.
module tb_pipeline_stall_controller;

  localparam int L    = 4;
  localparam int MT   = 64;
  localparam int CMAX = 15;

  logic       clk;
  logic       rst_n;
  logic       ld_use_hazard;
  logic       branch_taken;
  logic       mdu_start;
  logic       dmem_req;
  logic       dmem_ready;
  logic       clr_stats;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_write;
  logic       id_ex_bubble;
  logic       ex_mem_write;
  logic       ex_mem_bubble;
  logic       mdu_busy;
  logic       mem_timeout;
  logic [3:0] stall_cycles;
  logic [3:0] flush_count;
  logic [1:0] state_dbg;

  int errs   = 0;
  int checks = 0;

  pipeline_stall_controller #(
    .MDU_LATENCY (L),
    .MEM_TIMEOUT (MT),
    .CNT_W       (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ld_use_hazard (ld_use_hazard),
    .branch_taken  (branch_taken),
    .mdu_start     (mdu_start),
    .dmem_req      (dmem_req),
    .dmem_ready    (dmem_ready),
    .clr_stats     (clr_stats),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .id_ex_write   (id_ex_write),
    .id_ex_bubble  (id_ex_bubble),
    .ex_mem_write  (ex_mem_write),
    .ex_mem_bubble (ex_mem_bubble),
    .mdu_busy      (mdu_busy),
    .mem_timeout   (mem_timeout),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count),
    .state_dbg     (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // model: mode 0 normal, 1 waiting on memory, 2 mult/div
  int m_mode = 0, m_left = 0, m_waits = 0, m_tout = 0;
  int m_skip = 0, m_stall = 0, m_flush = 0;
  int n_mode, n_left, n_waits, n_tout;
  int n_skip, n_stall, n_flush;
  int e_pc, e_ifw, e_iff, e_idw, e_idb, e_exw, e_exb;
  int rules, fl;

  always @(negedge rst_n) begin
    m_mode = 0; m_left = 0; m_waits = 0; m_tout = 0;
    m_skip = 0; m_stall = 0; m_flush = 0;
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      m_mode = n_mode; m_left = n_left;
      m_waits = n_waits; m_tout = n_tout;
      m_skip = n_skip; m_stall = n_stall;
      m_flush = n_flush;
    end
  end

  always @(negedge clk) begin
    e_pc = 1; e_ifw = 1; e_iff = 0; e_idw = 1;
    e_idb = 0; e_exw = 1; e_exb = 0;
    n_mode = m_mode; n_left = m_left; n_waits = m_waits;
    n_tout = m_tout; n_skip = m_skip;
    n_stall = m_stall; n_flush = m_flush;
    rules = 0; fl = 0;
    if (rst_n !== 1'b1) begin
      e_pc = 0; e_ifw = 0; e_idw = 0; e_exw = 0;
    end else begin
      if (m_mode == 0) begin
        if (dmem_req && !dmem_ready) begin
          e_pc = 0; e_ifw = 0; e_idw = 0; e_exw = 0;
          n_mode = 1;
        end else rules = 1;
      end else if (m_mode == 1) begin
        if (!dmem_ready) begin
          e_pc = 0; e_ifw = 0; e_idw = 0; e_exw = 0;
          n_waits = (m_waits < MT) ? m_waits + 1 : MT;
          if (n_waits >= MT) n_tout = 1;
        end else begin
          n_waits = 0;
          n_mode = 0;
          rules = 1;
        end
      end else begin
        e_pc = 0; e_ifw = 0; e_idw = 0; e_exb = 1;
        n_left = m_left - 1;
        if (n_left == 0) begin
          n_mode = 0;
          n_skip = 1;
        end
      end
      if (rules == 1) begin
        n_skip = 0;
        if (branch_taken) begin
          e_iff = 1; e_idb = 1; fl = 1;
        end else if (mdu_start && m_skip == 0) begin
          e_pc = 0; e_ifw = 0; e_idw = 0; e_exb = 1;
          n_mode = 2;
          n_left = L - 1;
        end else if (ld_use_hazard) begin
          e_pc = 0; e_ifw = 0; e_idb = 1;
        end
      end
      if (e_pc == 0) n_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (fl == 1) n_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      if (clr_stats) begin
        n_stall = 0;
        n_flush = 0;
      end
    end
    chk("m_pc_write", 32'(pc_write), e_pc);
    chk("m_if_id_write", 32'(if_id_write), e_ifw);
    chk("m_if_id_flush", 32'(if_id_flush), e_iff);
    chk("m_id_ex_write", 32'(id_ex_write), e_idw);
    chk("m_id_ex_bubble", 32'(id_ex_bubble), e_idb);
    chk("m_ex_mem_write", 32'(ex_mem_write), e_exw);
    chk("m_ex_mem_bubble", 32'(ex_mem_bubble), e_exb);
    chk("m_mdu_busy", 32'(mdu_busy),
        (rst_n === 1'b1 && m_mode == 2) ? 1 : 0);
    chk("m_mem_timeout", 32'(mem_timeout), m_tout);
    chk("m_stall_cycles", 32'(stall_cycles), m_stall);
    chk("m_flush_count", 32'(flush_count), m_flush);
    chk("m_state", 32'(state_dbg), m_mode);
  end

  task automatic drive(input bit l, input bit b,
                       input bit m, input bit rq,
                       input bit rd, input bit c);
    ld_use_hazard = l;
    branch_taken  = b;
    mdu_start     = m;
    dmem_req      = rq;
    dmem_ready    = rd;
    clr_stats     = c;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick; tick;
    #2;
    chk("rst_pc", 32'(pc_write), 0);
    chk("rst_ifw", 32'(if_id_write), 0);
    chk("rst_stall", 32'(stall_cycles), 0);
    chk("rst_state", 32'(state_dbg), 0);
    rst_n = 1'b1;
    tick;
    #2 chk("idle_pc", 32'(pc_write), 1);

    tick;
    drive(1, 0, 0, 0, 0, 0);
    #2 chk("ld_pc", 32'(pc_write), 0);
    chk("ld_bub", 32'(id_ex_bubble), 1);
    tick;
    drive(0, 0, 0, 0, 0, 0);
    #2 chk("ld_stall", 32'(stall_cycles), 1);
    chk("ld_pc_after", 32'(pc_write), 1);

    tick;
    drive(1, 1, 0, 0, 0, 0);
    #2 chk("br_flush", 32'(if_id_flush), 1);
    chk("br_pc", 32'(pc_write), 1);
    chk("br_bub", 32'(id_ex_bubble), 1);
    tick;
    drive(0, 0, 0, 0, 0, 0);
    #2 chk("br_fc", 32'(flush_count), 1);
    chk("br_stall", 32'(stall_cycles), 1);

    tick;
    drive(0, 0, 1, 0, 0, 0);
    #2 chk("mdu_pc_t0", 32'(pc_write), 0);
    chk("mdu_exb_t0", 32'(ex_mem_bubble), 1);
    chk("mdu_busy_t0", 32'(mdu_busy), 0);
    tick;
    #2 chk("mdu_busy_t1", 32'(mdu_busy), 1);
    tick; tick;
    #2 chk("mdu_busy_t3", 32'(mdu_busy), 1);
    chk("mdu_pc_t3", 32'(pc_write), 0);
    tick;
    #2 chk("mdu_pc_t4", 32'(pc_write), 1);
    chk("mdu_busy_t4", 32'(mdu_busy), 0);
    chk("mdu_stall", 32'(stall_cycles), 5);
    tick;
    drive(0, 0, 0, 0, 0, 0);

    tick;
    drive(1, 0, 0, 0, 0, 0);
    repeat (20) tick;
    drive(0, 0, 0, 0, 0, 0);
    #2 chk("sat_stall", 32'(stall_cycles), 15);
    tick;
    drive(1, 0, 0, 0, 0, 1);
    tick;
    drive(0, 0, 0, 0, 0, 0);
    #2 chk("clr_stall", 32'(stall_cycles), 0);
    chk("clr_flush", 32'(flush_count), 0);

    tick;
    drive(0, 0, 0, 1, 0, 0);
    #2 chk("mem_pc", 32'(pc_write), 0);
    chk("mem_exw", 32'(ex_mem_write), 0);
    for (int i = 1; i <= 69; i++) begin
      tick;
      if (i == 64) begin
        #2 chk("tout_w64", 32'(mem_timeout), 0);
      end
      if (i == 65) begin
        #2 chk("tout_w65", 32'(mem_timeout), 1);
      end
    end
    tick;
    drive(0, 1, 0, 1, 1, 0);
    #2 chk("rel_flush", 32'(if_id_flush), 1);
    chk("rel_pc", 32'(pc_write), 1);
    chk("rel_state", 32'(state_dbg), 1);
    tick;
    drive(0, 0, 0, 0, 0, 0);
    #2 chk("rel_state_after", 32'(state_dbg), 0);
    chk("rel_fc", 32'(flush_count), 1);
    chk("rel_tout", 32'(mem_timeout), 1);

    tick;
    drive(0, 0, 1, 0, 0, 0);
    tick; tick;
    rst_n = 1'b0;
    #2 chk("mrst_pc", 32'(pc_write), 0);
    chk("mrst_exw", 32'(ex_mem_write), 0);
    chk("mrst_busy", 32'(mdu_busy), 0);
    chk("mrst_tout", 32'(mem_timeout), 0);
    tick;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #2 chk("mrst_state", 32'(state_dbg), 0);
    chk("mrst_pc_after", 32'(pc_write), 1);

    tick;
    drive(0, 1, 1, 0, 0, 0);
    #2 chk("mix_flush", 32'(if_id_flush), 1);
    chk("mix_pc", 32'(pc_write), 1);
    tick;
    drive(0, 0, 0, 0, 0, 0);
    #2 chk("mix_state", 32'(state_dbg), 0);
    chk("mix_fc", 32'(flush_count), 1);

    tick; tick;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
